i2s2_ctrl: RTL and testbench

Sequencer for the Pmod I2S2 codec. It generates the shared MCLK, SCLK and LRCK for the line-in ADC and the line-out DAC, deserialises 24-bit stereo ADC frames, and serialises 24-bit stereo DAC frames. It sits between the Pmod pins and the audio datapath: a valid/ready stream out for capture and a valid/ready stream in for playback. A warm-up phase discards codec start-up frames before streaming begins.

---
 rtl/i2s2_pkg.sv | 17 +
 rtl/i2s2_ctrl_if.sv | 33 +++
 rtl/i2s2_clkgen.sv | 34 +++
 rtl/i2s2_ctrl.sv | 128 ++++++++++++
 tb/tb_i2s2_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2s2_pkg.sv
// Shared types and constants for the Pmod I2S2 sequencer.
package i2s2_pkg;
    localparam int SAMPLE_W  = 24;
    localparam int SLOT_BITS = 32;

    typedef enum logic [1:0] {OFF, WARMUP, RUN} i2s2_state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } i2s2_frame_t;

    // Slot bits 1..24 carry sample data (MSB in slot 1); the rest are don't-care.
    function automatic logic in_data_slot(input logic [4:0] b);
        return (b >= 5'd1) && (b <= 5'(SAMPLE_W));
    endfunction
endpackage

// File: rtl/i2s2_ctrl_if.sv
// Pin and stream bundle of the I2S2 sequencer; master is the sequencer side.
interface i2s2_ctrl_if;
    import i2s2_pkg::*;

    logic                enable_in;
    logic                lin_sdout_in;
    logic                mclk_out;
    logic                sclk_out;
    logic                lrck_out;
    logic                lout_sdin_out;
    logic [SAMPLE_W-1:0] adc_left_out;
    logic [SAMPLE_W-1:0] adc_right_out;
    logic                adc_valid_out;
    logic                adc_ready_in;
    logic                adc_overflow_out;
    logic [SAMPLE_W-1:0] dac_left_in;
    logic [SAMPLE_W-1:0] dac_right_in;
    logic                dac_valid_in;
    logic                dac_ready_out;
    logic                dac_underrun_out;

    modport master (
        input  enable_in, lin_sdout_in, adc_ready_in, dac_left_in, dac_right_in, dac_valid_in,
        output mclk_out, sclk_out, lrck_out, lout_sdin_out, adc_left_out, adc_right_out,
               adc_valid_out, adc_overflow_out, dac_ready_out, dac_underrun_out
    );

    modport slave (
        output enable_in, lin_sdout_in, adc_ready_in, dac_left_in, dac_right_in, dac_valid_in,
        input  mclk_out, sclk_out, lrck_out, lout_sdin_out, adc_left_out, adc_right_out,
               adc_valid_out, adc_overflow_out, dac_ready_out, dac_underrun_out
    );
endinterface

// File: rtl/i2s2_clkgen.sv
// Free-running frame counter: codec clocks, SCLK edge strobes, frame wrap and slot index.
module i2s2_clkgen #(
    parameter int M = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       mclk,
    output logic       sclk,
    output logic       lrck,
    output logic       rise,
    output logic       fall,
    output logic       wrap,
    output logic [4:0] slot
);
    localparam int CW = M + 8;

    logic [CW-1:0] cnt;

    // Count while running; collapse to 0 the cycle after run drops so the pins go quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (run) cnt <= cnt + CW'(1);
        else          cnt <= '0;
    end

    assign mclk = cnt[M-1];
    assign sclk = cnt[M+1];
    assign lrck = cnt[M+7];
    assign slot = cnt[M+6:M+2];
    assign rise = (cnt[M+1:0] == {1'b1, {(M+1){1'b0}}});
    assign fall = (cnt[M+1:0] == '0);
    assign wrap = &cnt;
endmodule

// File: rtl/i2s2_ctrl.sv
// Pmod I2S2 sequencer: warm-up FSM, ADC deserialiser and DAC serialiser.
module i2s2_ctrl
    import i2s2_pkg::*;
#(
    parameter int MCLK_LOG2     = 1,
    parameter int WARMUP_FRAMES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    i2s2_ctrl_if.master io
);
    localparam int WW = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

    i2s2_state_t   state_q, state_d;
    logic [WW-1:0] warm_q, warm_d;
    logic          run, rise, fall, wrap, lrck;
    logic [4:0]    slot, bidx;
    logic          data_slot, adc_done, dac_rdy;

    logic [1:0][SAMPLE_W-1:0] adc_sr;   // [0] left, [1] right
    i2s2_frame_t              dac_buf;

    // Dropping enable wins over everything, so the counter is already 0 when OFF is entered.
    assign run = io.enable_in && (state_q != OFF);

    i2s2_clkgen #(.M(MCLK_LOG2)) u_clkgen (
        .clk  (clk_in),
        .rst_n(rst_in),
        .run  (run),
        .mclk (io.mclk_out),
        .sclk (io.sclk_out),
        .lrck (lrck),
        .rise (rise),
        .fall (fall),
        .wrap (wrap),
        .slot (slot)
    );

    assign io.lrck_out = lrck;
    assign data_slot   = in_data_slot(slot);
    assign bidx        = 5'(SAMPLE_W) - slot;
    assign adc_done    = run && (state_q == RUN) && rise && lrck && (slot == 5'(SAMPLE_W));
    assign dac_rdy     = io.enable_in && (state_q == RUN) && wrap;
    assign io.dac_ready_out = dac_rdy;

    // State and warm-up frame count register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= OFF;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    // Next state: leave WARMUP on the wrap that completes the last discarded frame.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (!io.enable_in) begin
            state_d = OFF;
            warm_d  = '0;
        end else begin
            case (state_q)
                OFF:     state_d = WARMUP;
                WARMUP:  if (wrap) begin
                             if (warm_q == WW'(WARMUP_FRAMES - 1)) state_d = RUN;
                             else                                  warm_d  = warm_q + WW'(1);
                         end
                default: ;
            endcase
        end
    end

    // ADC: sample on SCLK rise; the final right bit bypasses the shift register straight to the output.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            adc_sr              <= '0;
            io.adc_left_out     <= '0;
            io.adc_right_out    <= '0;
            io.adc_valid_out    <= 1'b0;
            io.adc_overflow_out <= 1'b0;
        end else if (!io.enable_in) begin
            adc_sr              <= '0;
            io.adc_left_out     <= '0;
            io.adc_right_out    <= '0;
            io.adc_valid_out    <= 1'b0;
            io.adc_overflow_out <= 1'b0;
        end else begin
            io.adc_overflow_out <= 1'b0;
            if (run && rise && data_slot) adc_sr[lrck][bidx] <= io.lin_sdout_in;
            if (adc_done) begin
                io.adc_left_out     <= adc_sr[0];
                io.adc_right_out    <= {adc_sr[1][SAMPLE_W-1:1], io.lin_sdout_in};
                io.adc_valid_out    <= 1'b1;
                io.adc_overflow_out <= io.adc_valid_out && !io.adc_ready_in;
            end else if (io.adc_valid_out && io.adc_ready_in) begin
                io.adc_valid_out <= 1'b0;
            end
        end
    end

    // DAC: load a frame (or zeros) at the wrap, shift it out on each SCLK fall of the next frame.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dac_buf             <= '0;
            io.dac_underrun_out <= 1'b0;
            io.lout_sdin_out    <= 1'b0;
        end else if (!io.enable_in) begin
            dac_buf             <= '0;
            io.dac_underrun_out <= 1'b0;
            io.lout_sdin_out    <= 1'b0;
        end else begin
            io.dac_underrun_out <= 1'b0;
            if (wrap) begin
                if (dac_rdy && io.dac_valid_in) begin
                    dac_buf <= '{left: io.dac_left_in, right: io.dac_right_in};
                end else begin
                    dac_buf             <= '0;
                    io.dac_underrun_out <= dac_rdy;
                end
            end
            if (run && fall)
                io.lout_sdin_out <= data_slot ? (lrck ? dac_buf.right[bidx] : dac_buf.left[bidx]) : 1'b0;
        end
    end
endmodule

// File: tb/tb_i2s2_ctrl.sv
// Bench for i2s2_ctrl: codec-side model derives slot positions from the SCLK/LRCK pins.
module tb_i2s2_ctrl;
    import i2s2_pkg::*;

    localparam int WF    = 4;
    localparam int FRAME = 512;
    localparam logic [47:0] FIX_ADC = {24'hF0AA11, 24'h0F55EE};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s2_ctrl_if bus();

    i2s2_ctrl #(.MCLK_LOG2(1), .WARMUP_FRAMES(WF)) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .io    (bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Codec model state.
    logic        p_sclk, p_lrck, en_p, p_rdy, p_dv;
    logic [23:0] p_dl, p_dr;
    int          rcnt, fi, b;
    logic [47:0] tx, cur, mexp;
    logic [1:0][23:0] w;
    logic        zbad, mv, mov, adc_fixed;
    logic        rise_e, fall_e, lr_chg, fstart, ch, done, exp_rdy, exp_udr, run_old;
    int          done_cnt = 0, obs_ovf = 0, obs_udr = 0;

    function automatic logic [47:0] pick_tx(input logic fixed);
        return fixed ? FIX_ADC : {24'($urandom), 24'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            p_sclk = 0; p_lrck = 0; en_p = 0; p_rdy = 0; p_dv = 0; p_dl = '0; p_dr = '0;
            rcnt = 0; fi = 0; cur = '0; w = '0; zbad = 0; mv = 0; mov = 0; mexp = '0;
            tx = pick_tx(adc_fixed);
            bus.lin_sdout_in = 1'b0;
        end else begin
            ch      = bus.lrck_out;
            rise_e  = en_p && !p_sclk && bus.sclk_out;
            fall_e  = en_p && p_sclk && !bus.sclk_out;
            lr_chg  = en_p && (p_lrck != ch);
            fstart  = lr_chg && !ch;
            exp_rdy = 1'b0;
            exp_udr = 1'b0;
            done    = 1'b0;
            if (fstart) begin
                run_old = (fi >= WF);
                exp_rdy = run_old;
                if (run_old && p_dv) cur = {p_dl, p_dr};
                else begin
                    cur     = '0;
                    exp_udr = run_old;
                end
                fi++;
                tx = pick_tx(adc_fixed);
            end
            chk("dac_ready", p_rdy, exp_rdy);
            chk("dac_underrun", bus.dac_underrun_out, exp_udr);
            obs_ovf += int'(bus.adc_overflow_out);
            obs_udr += int'(bus.dac_underrun_out);
            if (lr_chg) rcnt = 0;
            // Present the next slot's bit after every SCLK fall; data slots MSB first, others random.
            if (fall_e || lr_chg) begin
                b = rcnt;
                if (b >= 1 && b <= 24) bus.lin_sdout_in = ch ? tx[24-b] : tx[48-b];
                else                   bus.lin_sdout_in = 1'($urandom);
            end
            if (rise_e) begin
                b = rcnt;
                if (b >= 1 && b <= 24) w[ch][24-b] = bus.lout_sdin_out;
                else                   zbad = zbad | bus.lout_sdin_out;
                if (b == 31) begin
                    chk(ch ? "dac_right_word" : "dac_left_word", w[ch], ch ? cur[23:0] : cur[47:24]);
                    chk("dac_idle_bits", zbad, 1'b0);
                    w[ch] = '0;
                    zbad  = 1'b0;
                end
                if (ch && b == 24 && fi >= WF && bus.enable_in) done = 1'b1;
                rcnt++;
            end
            chk("adc_valid", bus.adc_valid_out, mv);
            chk("adc_overflow", bus.adc_overflow_out, mov);
            if (mv) chk("adc_data", {bus.adc_left_out, bus.adc_right_out}, mexp);
            if (!bus.enable_in) begin
                mv = 0; mov = 0;
            end else if (done) begin
                mov  = mv && !bus.adc_ready_in;
                mv   = 1'b1;
                mexp = tx;
                done_cnt++;
            end else begin
                mov = 1'b0;
                if (mv && bus.adc_ready_in) mv = 1'b0;
            end
            if (!bus.enable_in) begin
                rcnt = 0; fi = 0; cur = '0; w = '0; zbad = 0;
                tx = pick_tx(adc_fixed);
            end
            p_sclk = bus.sclk_out; p_lrck = bus.lrck_out; en_p = bus.enable_in;
            p_rdy  = bus.dac_ready_out; p_dv = bus.dac_valid_in;
            p_dl   = bus.dac_left_in;   p_dr = bus.dac_right_in;
        end
    end

    function automatic logic [63:0] all_out();
        return {8'd0, bus.mclk_out, bus.sclk_out, bus.lrck_out, bus.lout_sdin_out,
                bus.adc_valid_out, bus.adc_overflow_out, bus.dac_ready_out, bus.dac_underrun_out,
                bus.adc_left_out, bus.adc_right_out};
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic first_valid(input string tag);
        int cyc;
        cyc = 0;
        bus.enable_in = 1'b1;
        while (!bus.adc_valid_out && cyc < 8 * FRAME) begin step(1); cyc++; end
        chk({tag, "_latency"}, cyc, 1 + WF * FRAME + 256 + 24 * 8 + 4 + 1);
    endtask

    initial begin
        int cyc, d0, o0, u0;
        adc_fixed        = 1'b1;
        bus.enable_in    = 1'b0;
        bus.adc_ready_in = 1'b0;
        bus.dac_valid_in = 1'b0;
        bus.dac_left_in  = '0;
        bus.dac_right_in = '0;
        step(3);
        chk("reset_outputs", all_out(), 64'd0);
        rst_n = 1'b1;

        // Idle: enable low keeps every pin and stream output at 0.
        for (int i = 0; i < 2000; i++) begin
            step(1);
            chk("idle_outputs", all_out(), 64'd0);
        end

        // Warm-up, then first captured frame carries the fixed pattern.
        bus.adc_ready_in = 1'b1;
        first_valid("first_valid");
        chk("first_left",  bus.adc_left_out,  24'hF0AA11);
        chk("first_right", bus.adc_right_out, 24'h0F55EE);

        // Zero frames substituted while nothing is offered.
        u0 = obs_udr;
        step(FRAME);
        chk("underrun_per_frame", obs_udr - u0, 1);

        // Stall the consumer over two completions: exactly one overflow.
        adc_fixed = 1'b0;
        step(4);
        bus.adc_ready_in = 1'b0;
        d0 = done_cnt; o0 = obs_ovf; cyc = 0;
        while (done_cnt < d0 + 2 && cyc < 4 * FRAME) begin step(1); cyc++; end
        step(2);
        chk("overflow_wait", done_cnt - d0, 2);
        chk("overflow_once", obs_ovf - o0, 1);
        chk("valid_held", bus.adc_valid_out, 1'b1);
        bus.adc_ready_in = 1'b1;

        // Boundary samples on playback.
        bus.dac_left_in  = 24'h800001;
        bus.dac_right_in = 24'h7FFFFF;
        bus.dac_valid_in = 1'b1;
        step(3 * FRAME);

        // Random consumer/producer behaviour.
        for (int i = 0; i < 10 * FRAME; i++) begin
            bus.adc_ready_in = ($urandom_range(3) != 0);
            bus.dac_valid_in = 1'($urandom);
            bus.dac_left_in  = 24'($urandom);
            bus.dac_right_in = 24'($urandom);
            step(1);
        end

        // Drop enable mid-right-channel with a frame pending.
        bus.adc_ready_in = 1'b0;
        cyc = 0;
        while (!bus.lrck_out && cyc < FRAME) begin step(1); cyc++; end
        step(60);
        bus.enable_in = 1'b0;
        step(1);
        chk("off_clocks", {bus.mclk_out, bus.sclk_out, bus.lrck_out}, 3'b000);
        chk("off_valid", bus.adc_valid_out, 1'b0);
        chk("off_pulses", {bus.adc_overflow_out, bus.dac_underrun_out, bus.dac_ready_out}, 3'b000);
        step(20);
        chk("off_hold", all_out(), 64'd0);

        // Re-enable repeats the full warm-up.
        adc_fixed        = 1'b1;
        bus.adc_ready_in = 1'b1;
        bus.dac_valid_in = 1'b1;
        first_valid("rewarm");
        chk("rewarm_data", {bus.adc_left_out, bus.adc_right_out}, FIX_ADC);
        step(FRAME + 100);

        // Reset mid-frame clears everything at once.
        rst_n = 1'b0;
        bus.enable_in = 1'b0;
        #1;
        chk("reset_abort", all_out(), 64'd0);
        step(3);
        rst_n = 1'b1;
        step(5);
        chk("after_reset", all_out(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
